// File: rtl/srt_pkg.sv
// ----------------------------------------------------------------------------
// srt_pkg
//  Shared definitions for the SRT radix-4 divider and its reconstruction MAC.
//  Contents: radix and digit-width constants, 2-bit FSM state encoding.
//  No ports (package).
// ----------------------------------------------------------------------------
package srt_pkg;

   localparam int unsigned RADIX = 4;
   localparam int unsigned DIG_W = 2;

   // FSM state encoding (legacy-compatible constants, 2 bits)
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_CALC  = 2'd1;
   localparam logic [1:0] ST_ADD_R = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/srt_recon_mac_digit_mul.sv
// ----------------------------------------------------------------------------
// radix4_digit_mul
//  Combinational radix-4 digit multiple: o_mul = i_dig * i_d, picked from
//  {0, D, 2D, 3D}. 3D is formed as (D<<1)+D at WIDTH+2 bits, so no carry loss.
// Ports:
//  i_dig  in   DIG_W      radix-4 digit (0..3)
//  i_d    in   WIDTH      multiplicand (unsigned)
//  o_mul  out  WIDTH+2    digit multiple
// ----------------------------------------------------------------------------
module radix4_digit_mul
   import srt_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic [DIG_W-1:0] i_dig,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH+1:0] o_mul
);

   logic [WIDTH+1:0] w_d1;
   logic [WIDTH+1:0] w_d2;
   logic [WIDTH+1:0] w_d3;

   assign w_d1 = {2'b00, i_d};
   assign w_d2 = {1'b0, i_d, 1'b0};
   assign w_d3 = w_d2 + w_d1;

   always_comb begin
      o_mul = '0;
      unique case (i_dig)
         2'd0:    o_mul = '0;
         2'd1:    o_mul = w_d1;
         2'd2:    o_mul = w_d2;
         default: o_mul = w_d3;
      endcase
   end

endmodule

// File: rtl/srt_recon_mac.sv
// ----------------------------------------------------------------------------
// srt_recon_mac
//  Rebuilds the dividend N = Q*D + R from an SRT radix-4 divider's quotient,
//  divisor and remainder. Sequential radix-4 MAC: Q consumed two bits per
//  cycle, MSB digit first, followed by one cycle adding R.
// Ports:
//  clk     in   1          rising-edge clock
//  resetn  in   1          asynchronous active-low reset
//  start   in   1          request, sampled only in IDLE or DONE
//  Q,D,R   in   WIDTH      operands, captured on accepted start
//  busy    out  1          high in CALC and ADD_R
//  done    out  1          one-cycle pulse, N valid
//  N       out  2*WIDTH    result, held until the next result is written
// ----------------------------------------------------------------------------
module srt_recon_mac
   import srt_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               start,
   input  logic [WIDTH-1:0]   Q,
   input  logic [WIDTH-1:0]   D,
   input  logic [WIDTH-1:0]   R,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] N
);

   localparam int unsigned NDIG  = WIDTH / 2;
   localparam int unsigned CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NDIG - 1);

   logic [1:0]         r_state, w_state_d;
   logic [CNT_W-1:0]   r_cnt,   w_cnt_d;
   logic [WIDTH-1:0]   r_q,     w_q_d;
   logic [WIDTH-1:0]   r_d,     w_d_d;
   logic [WIDTH-1:0]   r_r,     w_r_d;
   logic [2*WIDTH-1:0] r_acc,   w_acc_d;
   logic [2*WIDTH-1:0] r_n,     w_n_d;

   logic               w_accept;
   logic [WIDTH+1:0]   w_mul;
   logic [2*WIDTH-1:0] w_mul_ext;
   logic [2*WIDTH-1:0] w_sum;

   radix4_digit_mul #(
      .WIDTH (WIDTH)
   ) u_digit_mul (
      .i_dig (r_q[WIDTH-1 -: DIG_W]),
      .i_d   (r_d),
      .o_mul (w_mul)
   );

   assign w_mul_ext = {{(WIDTH-2){1'b0}}, w_mul};
   assign w_sum     = r_acc + {{WIDTH{1'b0}}, r_r};
   assign w_accept  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

   always_comb begin
      w_state_d = r_state;
      w_cnt_d   = r_cnt;
      w_q_d     = r_q;
      w_d_d     = r_d;
      w_r_d     = r_r;
      w_acc_d   = r_acc;
      w_n_d     = r_n;
      case (r_state)
         ST_IDLE: begin
            if (start) w_state_d = ST_CALC;
         end
         ST_CALC: begin
            // Horner step: shift in one radix-4 digit's worth of product
            w_acc_d = (r_acc << 2) + w_mul_ext;
            w_q_d   = r_q << 2;
            w_cnt_d = r_cnt + CNT_W'(1);
            if (r_cnt == CNT_LAST) w_state_d = ST_ADD_R;
         end
         ST_ADD_R: begin
            w_acc_d   = w_sum;
            w_n_d     = w_sum;
            w_state_d = ST_DONE;
         end
         default: begin
            w_state_d = start ? ST_CALC : ST_IDLE;
         end
      endcase
      // Accept overrides: fresh operands, cleared accumulator; N untouched
      if (w_accept) begin
         w_q_d   = Q;
         w_d_d   = D;
         w_r_d   = R;
         w_acc_d = '0;
         w_cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_q     <= '0;
         r_d     <= '0;
         r_r     <= '0;
         r_acc   <= '0;
         r_n     <= '0;
      end else begin
         r_state <= w_state_d;
         r_cnt   <= w_cnt_d;
         r_q     <= w_q_d;
         r_d     <= w_d_d;
         r_r     <= w_r_d;
         r_acc   <= w_acc_d;
         r_n     <= w_n_d;
      end
   end

   // DONE lasts exactly one cycle, so decoding it gives the one-cycle pulse
   assign busy = (r_state == ST_CALC) || (r_state == ST_ADD_R);
   assign done = (r_state == ST_DONE);
   assign N    = r_n;

endmodule

// File: tb/tb_srt_recon_mac.sv
module tb_srt_recon_mac;

   localparam int unsigned WIDTH = 8;

   logic              clk;
   logic              resetn;
   logic              start;
   logic [WIDTH-1:0]  q_in, d_in, r_in;
   logic              busy, done;
   logic [2*WIDTH-1:0] n_out;

   int checks   = 0;
   int failures = 0;
   logic [31:0] prev_n = 0;

   srt_recon_mac #(
      .WIDTH (WIDTH)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .start  (start),
      .Q      (q_in),
      .D      (d_in),
      .R      (r_in),
      .busy   (busy),
      .done   (done),
      .N      (n_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One transaction driven from a negedge; optional ignored start pulse in CALC.
   task automatic run_op(input logic [7:0] q, input logic [7:0] d, input logic [7:0] r,
                         input bit scramble, input bit pulse_mid, input logic [7:0] q_mid);
      int edges;
      int busy_cnt;
      int overlap;
      int n_moved;
      bit got;
      logic [31:0] exp_n;
      exp_n = 32'(q) * 32'(d) + 32'(r);
      q_in = q; d_in = d; r_in = r; start = 1'b1;
      edges = 0; busy_cnt = 0; overlap = 0; n_moved = 0; got = 1'b0;
      while (!got && edges < 20) begin
         @(negedge clk);
         edges++;
         if (edges == 1) start = 1'b0;
         if (busy && done) overlap++;
         if (busy) begin
            busy_cnt++;
            if (32'(n_out) != prev_n) n_moved++;
            if (scramble) begin
               q_in = 8'($urandom); d_in = 8'($urandom); r_in = 8'($urandom);
            end
         end
         if (pulse_mid && edges == 2) begin
            start = 1'b1; q_in = q_mid;
         end
         if (pulse_mid && edges == 3) start = 1'b0;
         if (done) got = 1'b1;
      end
      check_eq("done_latency", 32'(edges), 32'd6);
      check_eq("busy_cycles", 32'(busy_cnt), 32'd5);
      check_eq("busy_done_overlap", 32'(overlap), 32'd0);
      check_eq("n_held_while_busy", 32'(n_moved), 32'd0);
      check_eq("n_result", 32'(n_out), exp_n);
      prev_n = exp_n;
      @(negedge clk);
      check_eq("done_single_pulse", 32'(done), 32'd0);
   endtask

   initial begin
      int edges;
      int bad;
      resetn = 1'b0; start = 1'b0; q_in = '0; d_in = '0; r_in = '0;
      repeat (3) @(negedge clk);
      check_eq("reset_busy", 32'(busy), 32'd0);
      check_eq("reset_done", 32'(done), 32'd0);
      check_eq("reset_n", 32'(n_out), 32'd0);
      resetn = 1'b1;
      @(negedge clk);

      run_op(8'd200, 8'd100, 8'd37, 1'b0, 1'b0, 8'd0);
      run_op(8'd0, 8'd123, 8'd9, 1'b0, 1'b0, 8'd0);
      run_op(8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0, 8'd0);
      run_op(8'd77, 8'd0, 8'd200, 1'b0, 1'b0, 8'd0);

      // Start while busy must be ignored
      run_op(8'd3, 8'd5, 8'd1, 1'b0, 1'b1, 8'd7);
      bad = 0;
      repeat (8) begin
         @(negedge clk);
         if (busy || done) bad++;
      end
      check_eq("ignored_start_idle", 32'(bad), 32'd0);
      check_eq("ignored_start_n", 32'(n_out), 32'd16);

      // Back-to-back with start held across DONE
      q_in = 8'd12; d_in = 8'd12; r_in = 8'd0; start = 1'b1;
      edges = 0;
      while (!done && edges < 20) begin
         @(negedge clk);
         edges++;
      end
      check_eq("chain_first_n", 32'(n_out), 32'd144);
      q_in = 8'd2; d_in = 8'd3; r_in = 8'd1;
      edges = 0;
      do begin
         @(negedge clk);
         edges++;
      end while (!done && edges < 20);
      start = 1'b0;
      check_eq("chain_gap", 32'(edges), 32'd6);
      check_eq("chain_second_n", 32'(n_out), 32'd7);
      prev_n = 32'd7;
      @(negedge clk);

      // Randomized transactions against Q*D+R
      for (int i = 0; i < 30; i++) begin
         logic [7:0] rq, rd, rr;
         rq = 8'($urandom); rd = 8'($urandom); rr = 8'($urandom);
         if ($urandom_range(0, 7) == 0) rq = 8'd0;
         if ($urandom_range(0, 7) == 0) rd = 8'd0;
         run_op(rq, rd, rr, 1'b1, 1'b0, 8'd0);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      // Asynchronous reset in the 3rd CALC cycle
      q_in = 8'd200; d_in = 8'd100; r_in = 8'd37; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("pre_reset_busy", 32'(busy), 32'd1);
      #2 resetn = 1'b0;
      #1;
      check_eq("async_reset_busy", 32'(busy), 32'd0);
      check_eq("async_reset_done", 32'(done), 32'd0);
      check_eq("async_reset_n", 32'(n_out), 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      bad = 0;
      repeat (10) begin
         @(negedge clk);
         if (busy || done || n_out != '0) bad++;
      end
      check_eq("post_reset_quiet", 32'(bad), 32'd0);
      prev_n = 32'd0;
      run_op(8'd19, 8'd23, 8'd5, 1'b1, 1'b0, 8'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
